// File: rtl/slot_alloc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slot_alloc_if: config, release and descriptor channels of the        |
// | slot allocation scheduler.                    Revision: 1.0          |
// +----------------------------------------------------------------------+
interface slot_alloc_if #(
  parameter int PORT_COUNT    = 2,
  parameter int CORE_COUNT    = 16,
  parameter int SLOT_COUNT    = 8,
  parameter int SLOT_WIDTH    = $clog2(SLOT_COUNT + 1),
  parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT),
  parameter int ID_SLOT_WIDTH = CORE_ID_WIDTH + SLOT_WIDTH
);
  logic                                cfg_valid;
  logic [CORE_ID_WIDTH-1:0]            cfg_core;
  logic [SLOT_WIDTH-1:0]               cfg_slot_count;
  logic                                cfg_ready;
  logic                                rel_valid;
  logic [CORE_ID_WIDTH-1:0]            rel_core;
  logic [SLOT_WIDTH-1:0]               rel_slot;
  logic                                rel_ready;
  logic [PORT_COUNT-1:0]               desc_valid;
  logic [PORT_COUNT*ID_SLOT_WIDTH-1:0] desc_data;
  logic [PORT_COUNT-1:0]               desc_ready;

  modport master (
    output cfg_valid, cfg_core, cfg_slot_count,
    output rel_valid, rel_core, rel_slot,
    output desc_ready,
    input  cfg_ready, rel_ready, desc_valid, desc_data
  );

  modport slave (
    input  cfg_valid, cfg_core, cfg_slot_count,
    input  rel_valid, rel_core, rel_slot,
    input  desc_ready,
    output cfg_ready, rel_ready, desc_valid, desc_data
  );
endinterface
`default_nettype wire

// File: rtl/slot_alloc_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slot_alloc_scheduler: per-core free-slot bitmaps with round-robin    |
// | port/core selection feeding one {core, slot} register per port.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module slot_alloc_scheduler #(
  parameter int PORT_COUNT    = 2,
  parameter int CORE_COUNT    = 16,
  parameter int SLOT_COUNT    = 8,
  parameter int SLOT_WIDTH    = $clog2(SLOT_COUNT + 1),
  parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT),
  parameter int ID_SLOT_WIDTH = CORE_ID_WIDTH + SLOT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CORE_COUNT-1:0]            core_enable,
  slot_alloc_if.slave                      bus,
  output logic [CORE_COUNT*SLOT_WIDTH-1:0] free_count,
  output logic                             err_double_free,
  output logic                             err_bad_slot
);

  localparam int c_PORT_ID_WIDTH = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

  logic [SLOT_COUNT-1:0]            r_bitmap     [CORE_COUNT];
  logic [SLOT_COUNT-1:0]            w_bitmap_nxt [CORE_COUNT];
  logic [SLOT_WIDTH-1:0]            w_count_nxt  [CORE_COUNT];
  logic [ID_SLOT_WIDTH-1:0]         r_desc_data  [PORT_COUNT];
  logic [PORT_COUNT-1:0]            r_desc_valid;
  logic [CORE_COUNT*SLOT_WIDTH-1:0] r_free_count;
  logic [c_PORT_ID_WIDTH-1:0]       r_port_ptr;
  logic [c_PORT_ID_WIDTH-1:0]       w_port_sel;
  logic [CORE_ID_WIDTH-1:0]         r_core_ptr;
  logic [CORE_ID_WIDTH-1:0]         w_core_sel;
  logic [SLOT_WIDTH-1:0]            w_slot_sel;
  logic [SLOT_COUNT-1:0]            w_sel_bitmap;
  logic [PORT_COUNT-1:0]            w_need;
  logic [CORE_COUNT-1:0]            w_elig;
  logic                             w_port_found;
  logic                             w_core_found;
  logic                             w_alloc;
  logic                             w_dbl;
  logic                             w_bad;
  logic                             r_err_dbl;
  logic                             r_err_bad;

  // Requests and round-robin grants; the first pass covers indices at or
  // above the pointer, the second pass wraps around.
  always_comb begin
    w_need       = '0;
    w_elig       = '0;
    w_port_found = 1'b0;
    w_port_sel   = '0;
    w_core_found = 1'b0;
    w_core_sel   = '0;
    for (int p = 0; p < PORT_COUNT; p++)
      w_need[p] = !r_desc_valid[p] || bus.desc_ready[p];
    for (int c = 0; c < CORE_COUNT; c++)
      w_elig[c] = core_enable[c] && (|r_bitmap[c]) &&
                  !(bus.cfg_valid && (bus.cfg_core == CORE_ID_WIDTH'(c)));
    for (int p = 0; p < PORT_COUNT; p++)
      if (!w_port_found && w_need[p] && (p >= int'(r_port_ptr))) begin
        w_port_found = 1'b1;
        w_port_sel   = c_PORT_ID_WIDTH'(p);
      end
    for (int p = 0; p < PORT_COUNT; p++)
      if (!w_port_found && w_need[p]) begin
        w_port_found = 1'b1;
        w_port_sel   = c_PORT_ID_WIDTH'(p);
      end
    for (int c = 0; c < CORE_COUNT; c++)
      if (!w_core_found && w_elig[c] && (c >= int'(r_core_ptr))) begin
        w_core_found = 1'b1;
        w_core_sel   = CORE_ID_WIDTH'(c);
      end
    for (int c = 0; c < CORE_COUNT; c++)
      if (!w_core_found && w_elig[c]) begin
        w_core_found = 1'b1;
        w_core_sel   = CORE_ID_WIDTH'(c);
      end
    w_alloc = w_port_found && w_core_found;
  end

  // Lowest free slot of the granted core
  always_comb begin
    w_sel_bitmap = '0;
    w_slot_sel   = '0;
    for (int c = 0; c < CORE_COUNT; c++)
      if (w_core_sel == CORE_ID_WIDTH'(c))
        w_sel_bitmap = r_bitmap[c];
    for (int k = SLOT_COUNT - 1; k >= 0; k--)
      if (w_sel_bitmap[k])
        w_slot_sel = SLOT_WIDTH'(k + 1);
  end

  // Config overrides everything on its core; otherwise the allocation clears
  // and the release sets, both judged against the pre-edge bitmap.
  always_comb begin
    w_dbl = 1'b0;
    w_bad = 1'b0;
    for (int c = 0; c < CORE_COUNT; c++) begin
      w_bitmap_nxt[c] = r_bitmap[c];
      if (bus.cfg_valid && (bus.cfg_core == CORE_ID_WIDTH'(c))) begin
        for (int k = 0; k < SLOT_COUNT; k++)
          w_bitmap_nxt[c][k] = (k < int'(bus.cfg_slot_count));
      end else begin
        if (w_alloc && (w_core_sel == CORE_ID_WIDTH'(c))) begin
          for (int k = 0; k < SLOT_COUNT; k++)
            if (int'(w_slot_sel) == k + 1)
              w_bitmap_nxt[c][k] = 1'b0;
        end
        if (bus.rel_valid && (bus.rel_core == CORE_ID_WIDTH'(c))) begin
          if ((bus.rel_slot == '0) || (int'(bus.rel_slot) > SLOT_COUNT)) begin
            w_bad = 1'b1;
          end else begin
            for (int k = 0; k < SLOT_COUNT; k++)
              if (int'(bus.rel_slot) == k + 1) begin
                if (r_bitmap[c][k])
                  w_dbl = 1'b1;
                else
                  w_bitmap_nxt[c][k] = 1'b1;
              end
          end
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CORE_COUNT; c++) begin
      w_count_nxt[c] = '0;
      for (int k = 0; k < SLOT_COUNT; k++)
        if (w_bitmap_nxt[c][k])
          w_count_nxt[c] = w_count_nxt[c] + SLOT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CORE_COUNT; c++)
        r_bitmap[c] <= '0;
      for (int p = 0; p < PORT_COUNT; p++)
        r_desc_data[p] <= '0;
      r_desc_valid <= '0;
      r_free_count <= '0;
      r_port_ptr   <= '0;
      r_core_ptr   <= '0;
      r_err_dbl    <= 1'b0;
      r_err_bad    <= 1'b0;
    end else begin
      for (int c = 0; c < CORE_COUNT; c++) begin
        r_bitmap[c]                                <= w_bitmap_nxt[c];
        r_free_count[c*SLOT_WIDTH +: SLOT_WIDTH] <= w_count_nxt[c];
      end
      for (int p = 0; p < PORT_COUNT; p++) begin
        if (w_alloc && (w_port_sel == c_PORT_ID_WIDTH'(p))) begin
          r_desc_valid[p] <= 1'b1;
          r_desc_data[p]  <= {w_core_sel, w_slot_sel};
        end else if (bus.desc_ready[p]) begin
          r_desc_valid[p] <= 1'b0;
        end
      end
      if (w_alloc) begin
        r_port_ptr <= (int'(w_port_sel) == PORT_COUNT - 1) ? '0
                      : w_port_sel + c_PORT_ID_WIDTH'(1);
        r_core_ptr <= (int'(w_core_sel) == CORE_COUNT - 1) ? '0
                      : w_core_sel + CORE_ID_WIDTH'(1);
      end
      if (w_dbl) r_err_dbl <= 1'b1;
      if (w_bad) r_err_bad <= 1'b1;
    end
  end

  for (genvar p = 0; p < PORT_COUNT; p++) begin : g_desc
    assign bus.desc_data[p*ID_SLOT_WIDTH +: ID_SLOT_WIDTH] = r_desc_data[p];
  end

  assign bus.desc_valid    = r_desc_valid;
  assign bus.cfg_ready     = 1'b1;
  assign bus.rel_ready     = 1'b1;
  assign free_count        = r_free_count;
  assign err_double_free   = r_err_dbl;
  assign err_bad_slot      = r_err_bad;

endmodule
`default_nettype wire

// File: doc/slot_alloc_scheduler.md
Name: slot_alloc_scheduler

Overview:
- Replaces the per-core slot-descriptor FIFOs and max-count core selection with free-slot bitmaps and round-robin core selection.
- Keeps one prefetched {core, slot} descriptor per ingress port, so each port's next packet has its destination ready.
- Cores configure their slot count and return slots after transmit through a config channel and a release channel.
- Sits between the ctrl_s message decode and the per-port tdest stamping logic.

Parameters:
PORT_COUNT, 2, number of ingress ports with a descriptor holding register
CORE_COUNT, 16, number of cores
SLOT_COUNT, 8, maximum slots per core; slot ids are 1..SLOT_COUNT
SLOT_WIDTH, $clog2(SLOT_COUNT+1), slot id width
CORE_ID_WIDTH, $clog2(CORE_COUNT), core id width
ID_SLOT_WIDTH, CORE_ID_WIDTH+SLOT_WIDTH, descriptor width {core, slot}

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
core_enable  in  CORE_COUNT  1 = core eligible for new allocations
cfg_valid  in  1  load slot count for one core
cfg_core  in  CORE_ID_WIDTH  core being configured
cfg_slot_count  in  SLOT_WIDTH  number of slots for that core
cfg_ready  out  1  config accepted
rel_valid  in  1  slot returned by a core
rel_core  in  CORE_ID_WIDTH  returning core
rel_slot  in  SLOT_WIDTH  returned slot id
rel_ready  out  1  release accepted; tied 1
desc_valid  out  PORT_COUNT  holding register full
desc_data  out  PORT_COUNT*ID_SLOT_WIDTH  {core, slot} per port
desc_ready  in  PORT_COUNT  port consumes its descriptor
free_count  out  CORE_COUNT*SLOT_WIDTH  popcount of each core's bitmap
err_double_free  out  1  sticky error flag
err_bad_slot  out  1  sticky error flag

Behaviour:
Reset (rst_n low, async):
- All bitmaps are 0. No core has slots until it is configured.
- desc_valid = 0, both round-robin pointers = 0, error flags = 0, cfg_ready = 1, free_count = 0.
- Reset mid-operation discards outstanding descriptors. Cores must be re-configured after reset.

State per core: a SLOT_COUNT-bit free bitmap. Bit k represents slot k+1.

Config:
- On cfg_valid, the core's bitmap becomes the low min(cfg_slot_count, SLOT_COUNT) bits set. Applied at the next edge.
- A count of 0 empties the core's bitmap.
- cfg_ready is always 1. Config takes one cycle.
- A configured core is excluded from allocation in the same cycle.

Release:
- On rel_valid with 1 <= rel_slot <= SLOT_COUNT, set bit rel_slot-1.
- If that bit is already 1, set err_double_free. The bitmap is unchanged.
- If rel_slot is 0 or greater than SLOT_COUNT, set err_bad_slot and ignore the release.
- If cfg_valid and rel_valid target the same core in the same cycle, the config wins and the release is dropped without an error.

Port holding registers:
- A port is "needing" when !desc_valid, or desc_valid && desc_ready. This allows back-to-back consumption.
- On desc_valid && desc_ready with no refill, desc_valid clears at the next edge. desc_data holds until refilled.

Allocation (at most one per cycle):
- Eligible core: core_enable=1, bitmap != 0, and not the cfg_core of this cycle.
- Port choice: round-robin among needing ports, starting at port_ptr.
- Core choice: round-robin among eligible cores, starting at core_ptr.
- Slot choice: lowest set bit of the chosen core's bitmap. Slot id = index+1.
- At the next edge:
  - the chosen bit clears;
  - the chosen port loads {core, slot} and sets desc_valid;
  - port_ptr = chosen port + 1 (mod PORT_COUNT);
  - core_ptr = chosen core + 1 (mod CORE_COUNT).
- Latency: one cycle from a needing port plus an eligible core to desc_valid.
- No eligible core or no needing port: nothing changes and the pointers hold.

Simultaneous events:
- Eligibility and allocation use the pre-edge bitmap.
- Allocation and a release on the same core in the same cycle both apply. Allocation clears its bit and the release sets a different bit.
- A release of the exact bit being allocated is by definition a double-free. The flag is set and the bit ends cleared.

Other rules:
- free_count is registered and reflects the post-edge bitmap.
- Disabling a core does not revoke descriptors already held in port registers.
- Error flags clear only on reset.

Test Plan:
1. Configure core0=3, core1=2, all enabled; port0 holds desc_ready=1 for 5 cycles -> descriptors {0,1},{1,1},{0,2},{1,2},{0,3}; then desc_valid[0] stays 0; free_count all 0.
2. Release core1 slot 2 while a port is starving -> desc_valid rises the cycle after the release edge with {1,2}.
3. Both ports needing, cores 0..3 configured to 8 -> grants alternate port0, port1 with cores 0,1,2,3 in order, one per cycle.
4. Release core2 slot 3 twice -> err_double_free=1 after the second; free_count[2] increments once. Release slot 0 -> err_bad_slot=1.
5. cfg core5=4 and rel core5 slot 7 in the same cycle -> bitmap 0x0F, no error; core5 not allocated that cycle.
6. Assert rst_n low while desc_valid=2'b11 -> desc_valid=0 immediately; after release from reset, no allocation until a cfg is applied.
